// File: rtl/logic_unit_pkg.sv
// Shared encodings for the multi-cycle logic unit: operation select codes
// and FSM state codes.
package logic_unit_pkg;

    localparam logic [2:0] OP_AND   = 3'b000;
    localparam logic [2:0] OP_OR    = 3'b001;
    localparam logic [2:0] OP_XOR   = 3'b010;
    localparam logic [2:0] OP_NOR   = 3'b011;
    localparam logic [2:0] OP_NAND  = 3'b100;
    localparam logic [2:0] OP_XNOR  = 3'b101;
    localparam logic [2:0] OP_ANDN  = 3'b110;
    localparam logic [2:0] OP_PASSA = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/logic_chunk_op.sv
// Combinational 8-way bitwise operation applied to one CHUNK-wide slice.
module logic_chunk_op
    import logic_unit_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [2:0]       op,
    input  logic [CHUNK-1:0] a_slice,
    input  logic [CHUNK-1:0] b_slice,
    output logic [CHUNK-1:0] r_slice
);

    always_comb begin
        // NOTE: default assignment first so no path leaves r_slice unassigned (no latch).
        r_slice = '0;
        case (op)
            OP_AND:   r_slice = a_slice & b_slice;
            OP_OR:    r_slice = a_slice | b_slice;
            OP_XOR:   r_slice = a_slice ^ b_slice;
            OP_NOR:   r_slice = ~(a_slice | b_slice);
            OP_NAND:  r_slice = ~(a_slice & b_slice);
            OP_XNOR:  r_slice = ~(a_slice ^ b_slice);
            OP_ANDN:  r_slice = a_slice & ~b_slice;
            OP_PASSA: r_slice = a_slice;
            default:  r_slice = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit: latches operands on acceptance, then
// produces CHUNK result bits per cycle plus zero and parity flags.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             nz_q, nz_d, par_q, par_d;
    logic             zero_q, zero_d, parity_q, parity_d;
    logic [CHUNK-1:0] r_slice;

    logic_chunk_op #(.CHUNK(CHUNK)) u_chunk_op (
        .op      (op_q),
        .a_slice (a_q[int'(count_q)*CHUNK +: CHUNK]),
        .b_slice (b_q[int'(count_q)*CHUNK +: CHUNK]),
        .r_slice (r_slice)
    );

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            nz_q     <= 1'b0;
            par_q    <= 1'b0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            nz_q     <= nz_d;
            par_q    <= par_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid) state_d = ST_RUN;
            ST_RUN:  if (count_q == LAST) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: load on acceptance, then fold one slice per RUN cycle.
    always_comb begin
        count_d  = count_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        nz_d     = nz_q;
        par_d    = par_q;
        zero_d   = zero_q;
        parity_d = parity_q;
        if (state_q == ST_IDLE && in_valid) begin
            op_d     = op;
            a_d      = a;
            b_d      = b;
            result_d = '0;
            nz_d     = 1'b0;
            par_d    = 1'b0;
            zero_d   = 1'b0;
            parity_d = 1'b0;
            count_d  = '0;
        end else if (state_q == ST_RUN) begin
            result_d[int'(count_q)*CHUNK +: CHUNK] = r_slice;
            nz_d  = nz_q | (|r_slice);
            par_d = par_q ^ (^r_slice);
            if (count_q == LAST) begin
                count_d  = '0;
                zero_d   = ~nz_d;
                parity_d = par_d;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_comb begin
        in_ready  = (state_q == ST_IDLE) && !rst;
        out_valid = (state_q == ST_DONE);
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign parity = parity_q;

endmodule
